// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS control path: state codes, opcodes,
// ALU/mux select values and the bundled control-word type.
package mips_pkg;

   typedef enum logic [3:0] {
      S_FETCH     = 4'd0,
      S_DECODE    = 4'd1,
      S_MEM_ADDR  = 4'd2,
      S_MEM_READ  = 4'd3,
      S_MEM_WB    = 4'd4,
      S_MEM_WRITE = 4'd5,
      S_EXECUTE   = 4'd6,
      S_ALU_WB    = 4'd7,
      S_BRANCH    = 4'd8,
      S_ADDI_EX   = 4'd9,
      S_ADDI_WB   = 4'd10,
      S_JUMP      = 4'd11,
      S_HALT      = 4'd12
   } state_e;

   localparam logic [5:0] OP_RTYPE = 6'd0;
   localparam logic [5:0] OP_LW    = 6'd35;
   localparam logic [5:0] OP_SW    = 6'd43;
   localparam logic [5:0] OP_BEQ   = 6'd4;
   localparam logic [5:0] OP_ADDI  = 6'd8;
   localparam logic [5:0] OP_J     = 6'd2;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   localparam logic [1:0] ALUB_REG_B   = 2'b00;
   localparam logic [1:0] ALUB_FOUR    = 2'b01;
   localparam logic [1:0] ALUB_IMM     = 2'b10;
   localparam logic [1:0] ALUB_IMM_SH2 = 2'b11;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   typedef struct packed {
      logic       pc_en;
      logic       i_or_d;
      logic       mem_read;
      logic       mem_write;
      logic       ir_write;
      logic       mem_to_reg;
      logic       reg_dst;
      logic       reg_write;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
      logic [1:0] pc_source;
      logic       illegal;
      logic       halted;
   } ctrl_t;

   function automatic logic is_known_op(input logic [5:0] op);
      return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
             (op == OP_BEQ)   || (op == OP_ADDI) || (op == OP_J);
   endfunction

endpackage

// File: rtl/mips_multicycle_control_if.sv
// Control-to-datapath bundle: instruction/status inputs to the control FSM and
// every enable and mux select it drives back into the datapath.
interface mips_multicycle_control_if;

   logic [5:0] opcode;
   logic       zero;
   logic       mem_ready;

   logic       pc_en;
   logic       i_or_d;
   logic       mem_read;
   logic       mem_write;
   logic       ir_write;
   logic       mem_to_reg;
   logic       reg_dst;
   logic       reg_write;
   logic       alu_src_a;
   logic [1:0] alu_src_b;
   logic [1:0] alu_op;
   logic [1:0] pc_source;
   logic       illegal;
   logic       halted;
   logic [3:0] state;

   modport master (
      input  opcode, zero, mem_ready,
      output pc_en, i_or_d, mem_read, mem_write, ir_write, mem_to_reg,
             reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source,
             illegal, halted, state
   );

   modport slave (
      output opcode, zero, mem_ready,
      input  pc_en, i_or_d, mem_read, mem_write, ir_write, mem_to_reg,
             reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source,
             illegal, halted, state
   );

endinterface

// File: rtl/mips_control_decode.sv
// Purely combinational state-to-control-word decoder; only the memory-ready
// enables, the branch PC enable and the illegal flag look at live inputs.
module mips_control_decode
   import mips_pkg::*;
(
   input  logic [3:0] state,
   input  logic [5:0] opcode,
   input  logic       zero,
   input  logic       mem_ready,
   output ctrl_t      ctrl
);

   always_comb begin
      // NOTE: default the whole word first so no path through the case leaves a field unassigned (no latches).
      ctrl = '0;
      case (state)
         S_FETCH: begin
            ctrl.mem_read  = 1'b1;
            ctrl.alu_src_b = ALUB_FOUR;
            ctrl.alu_op    = ALUOP_ADD;
            ctrl.pc_source = PCSRC_ALU;
            // PC and IR load only on the cycle the fetch actually completes.
            ctrl.ir_write  = mem_ready;
            ctrl.pc_en     = mem_ready;
         end
         S_DECODE: begin
            ctrl.alu_src_b = ALUB_IMM_SH2;
            ctrl.alu_op    = ALUOP_ADD;
            ctrl.illegal   = !is_known_op(opcode);
         end
         S_MEM_ADDR, S_ADDI_EX: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = ALUB_IMM;
            ctrl.alu_op    = ALUOP_ADD;
         end
         S_MEM_READ: begin
            ctrl.mem_read = 1'b1;
            ctrl.i_or_d   = 1'b1;
         end
         S_MEM_WB: begin
            ctrl.reg_write  = 1'b1;
            ctrl.mem_to_reg = 1'b1;
         end
         S_MEM_WRITE: begin
            ctrl.mem_write = 1'b1;
            ctrl.i_or_d    = 1'b1;
         end
         S_EXECUTE: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = ALUB_REG_B;
            ctrl.alu_op    = ALUOP_FUNCT;
         end
         S_ALU_WB: begin
            ctrl.reg_write = 1'b1;
            ctrl.reg_dst   = 1'b1;
         end
         S_BRANCH: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = ALUB_REG_B;
            ctrl.alu_op    = ALUOP_SUB;
            ctrl.pc_source = PCSRC_ALUOUT;
            ctrl.pc_en     = zero;
         end
         S_ADDI_WB: begin
            ctrl.reg_write = 1'b1;
         end
         S_JUMP: begin
            ctrl.pc_source = PCSRC_JUMP;
            ctrl.pc_en     = 1'b1;
         end
         S_HALT: begin
            ctrl.halted = 1'b1;
         end
         default: ctrl = '0;
      endcase
   end

endmodule

// File: rtl/mips_multicycle_control.sv
// Multicycle MIPS main control: state register plus next-state logic, with the
// control word decoded from the current state and forced to zero during reset.
module mips_multicycle_control
   import mips_pkg::*;
#(
   parameter bit TRAP_ON_ILLEGAL = 1'b1
) (
   input  logic                              clk,
   input  logic                              reset_n,
   mips_multicycle_control_if.master         bus
);

   state_e state_q;
   state_e state_d;
   ctrl_t  ctrl_raw;
   ctrl_t  ctrl_out;

   always_comb begin
      state_d = S_FETCH;
      case (state_q)
         S_FETCH:     state_d = bus.mem_ready ? S_DECODE : S_FETCH;
         S_DECODE: begin
            case (bus.opcode)
               OP_RTYPE:     state_d = S_EXECUTE;
               OP_LW, OP_SW: state_d = S_MEM_ADDR;
               OP_BEQ:       state_d = S_BRANCH;
               OP_ADDI:      state_d = S_ADDI_EX;
               OP_J:         state_d = S_JUMP;
               default:      state_d = TRAP_ON_ILLEGAL ? S_HALT : S_FETCH;
            endcase
         end
         S_MEM_ADDR:  state_d = (bus.opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
         S_MEM_READ:  state_d = bus.mem_ready ? S_MEM_WB : S_MEM_READ;
         S_MEM_WB:    state_d = S_FETCH;
         S_MEM_WRITE: state_d = bus.mem_ready ? S_FETCH : S_MEM_WRITE;
         S_EXECUTE:   state_d = S_ALU_WB;
         S_ALU_WB:    state_d = S_FETCH;
         S_BRANCH:    state_d = S_FETCH;
         S_ADDI_EX:   state_d = S_ADDI_WB;
         S_ADDI_WB:   state_d = S_FETCH;
         S_JUMP:      state_d = S_FETCH;
         S_HALT:      state_d = S_HALT;
         default:     state_d = S_FETCH;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      // NOTE: non-blocking assignment for state so every flop samples pre-edge values.
      if (!reset_n) state_q <= S_FETCH;
      else          state_q <= state_d;
   end

   mips_control_decode u_decode (
      .state     (state_q),
      .opcode    (bus.opcode),
      .zero      (bus.zero),
      .mem_ready (bus.mem_ready),
      .ctrl      (ctrl_raw)
   );

   // Reset gates the word combinationally so no write escapes while reset_n is low.
   assign ctrl_out = reset_n ? ctrl_raw : '0;

   assign bus.pc_en      = ctrl_out.pc_en;
   assign bus.i_or_d     = ctrl_out.i_or_d;
   assign bus.mem_read   = ctrl_out.mem_read;
   assign bus.mem_write  = ctrl_out.mem_write;
   assign bus.ir_write   = ctrl_out.ir_write;
   assign bus.mem_to_reg = ctrl_out.mem_to_reg;
   assign bus.reg_dst    = ctrl_out.reg_dst;
   assign bus.reg_write  = ctrl_out.reg_write;
   assign bus.alu_src_a  = ctrl_out.alu_src_a;
   assign bus.alu_src_b  = ctrl_out.alu_src_b;
   assign bus.alu_op     = ctrl_out.alu_op;
   assign bus.pc_source  = ctrl_out.pc_source;
   assign bus.illegal    = ctrl_out.illegal;
   assign bus.halted     = ctrl_out.halted;
   assign bus.state      = reset_n ? state_q : 4'd0;

endmodule
